// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD VRAM scheduler: FSM encoding, default line length, pixel word.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOST  = 2'd3
    } state_t;

    localparam int LINE_WORDS_DEF = 800;

    typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/lcd_fetch_counter.sv
// Word index within the current line plus the per-line VRAM base address.
// Base advances by one line stride per completed line and wraps silently at 2**ADDR_W.
module lcd_fetch_counter
    import lcd_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int LB_AW      = 10
) (
    input  logic              PixelClk,
    input  logic              nRST,
    input  logic              cnt_clr,
    input  logic              cnt_inc,
    input  logic              base_zero,
    input  logic              base_adv,
    output logic [LB_AW-1:0]  cnt,
    output logic [ADDR_W-1:0] base,
    output logic              cnt_last
);

    logic [LB_AW-1:0]  cnt_q,  cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + LB_AW'(1);
        end

        base_d = base_q;
        if (base_zero) begin
            base_d = '0;
        end else if (base_adv) begin
            base_d = base_q + ADDR_W'(LINE_WORDS);
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            cnt_q  <= '0;
            base_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            base_q <= base_d;
        end
    end

    assign cnt      = cnt_q;
    assign base     = base_q;
    assign cnt_last = (cnt_q == LB_AW'(LINE_WORDS - 1));

endmodule

// File: rtl/lcd_vram_scheduler.sv
// Arbitrates the single-port VRAM: line prefetch into the LCD line buffer has priority, host writes fill idle cycles.
// mem_* are registered on the request-sampling edge; line-buffer writes trail each read by one cycle.
module lcd_vram_scheduler
    import lcd_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int LB_AW      = 10
) (
    input  logic              PixelClk,
    input  logic              nRST,
    input  logic              frame_start,
    input  logic              line_req,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              fetch_done,
    output logic              err_overrun
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic              host_ack_q, host_ack_d;
    logic              fetch_done_q, fetch_done_d;
    logic              err_overrun_q, err_overrun_d;
    logic              zero_pend_q, zero_pend_d;
    logic              lb_we_q, lb_we_d;
    logic [LB_AW-1:0]  lb_addr_q, lb_addr_d;

    logic              cnt_clr, cnt_inc, base_zero, base_adv, cnt_last;
    logic [LB_AW-1:0]  cnt;
    logic [ADDR_W-1:0] base;

    lcd_fetch_counter #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS),
        .LB_AW      (LB_AW)
    ) u_cnt (
        .PixelClk  (PixelClk),
        .nRST      (nRST),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .base_zero (base_zero),
        .base_adv  (base_adv),
        .cnt       (cnt),
        .base      (base),
        .cnt_last  (cnt_last)
    );

    always_comb begin
        state_d       = state_q;
        mem_re_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        host_ack_d    = 1'b0;
        fetch_done_d  = 1'b0;
        err_overrun_d = err_overrun_q & ~frame_start;
        zero_pend_d   = zero_pend_q;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        base_zero     = 1'b0;
        base_adv      = 1'b0;

        // A line request always (re)starts the fetch from word 0, from any state.
        if (line_req) begin
            if (state_q == ST_FETCH || state_q == ST_DRAIN) begin
                err_overrun_d = 1'b1;
            end
            state_d    = ST_FETCH;
            mem_re_d   = 1'b1;
            mem_addr_d = frame_start ? '0 : base;
            cnt_clr    = 1'b1;
            if (frame_start) begin
                base_zero   = 1'b1;
                zero_pend_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    base_zero = frame_start;
                    if (host_req) begin
                        state_d     = ST_HOST;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = host_addr;
                        mem_wdata_d = host_wdata;
                        host_ack_d  = 1'b1;
                    end
                end
                ST_HOST: begin
                    base_zero = frame_start;
                    state_d   = ST_IDLE;
                end
                ST_FETCH: begin
                    // A frame restart mid-line must not disturb the addresses already in flight.
                    if (frame_start) begin
                        zero_pend_d = 1'b1;
                    end
                    if (cnt_last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_inc    = 1'b1;
                        mem_re_d   = 1'b1;
                        mem_addr_d = base + ADDR_W'(cnt) + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    fetch_done_d = 1'b1;
                    state_d      = ST_IDLE;
                    if (zero_pend_q || frame_start) begin
                        base_zero   = 1'b1;
                        zero_pend_d = 1'b0;
                    end else begin
                        base_adv = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        lb_we_d   = mem_re_q;
        lb_addr_d = mem_re_q ? cnt : '0;
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_IDLE;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            host_ack_q    <= 1'b0;
            fetch_done_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            zero_pend_q   <= 1'b0;
            lb_we_q       <= 1'b0;
            lb_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            host_ack_q    <= host_ack_d;
            fetch_done_q  <= fetch_done_d;
            err_overrun_q <= err_overrun_d;
            zero_pend_q   <= zero_pend_d;
            lb_we_q       <= lb_we_d;
            lb_addr_q     <= lb_addr_d;
        end
    end

    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign host_ack    = host_ack_q;
    assign fetch_done  = fetch_done_q;
    assign err_overrun = err_overrun_q;
    assign lb_we       = lb_we_q;
    assign lb_addr     = lb_addr_q;
    // Read data is only valid in the return cycle, so it passes straight through.
    assign lb_wdata    = lb_we_q ? mem_rdata : '0;

endmodule
